// File: rtl/display_scheduler_if.sv
// display_scheduler_if: request/data bundle from the value sources and the
// grant plus seven-segment scan signals returned by the scheduler.
interface display_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [16*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]    grant;
   logic [6:0]            cathode;
   logic [7:0]            anode;

   // Value sources and the board-level test harness.
   modport master (
      output req,
      output data,
      input  grant,
      input  cathode,
      input  anode
   );

   // The scheduler itself.
   modport slave (
      input  req,
      input  data,
      output grant,
      output cathode,
      output anode
   );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: shares the 8-digit seven-segment display between up to
// four 16-bit sources. Round-robin ownership with a minimum dwell in frames,
// a per-frame latch of the owner's value (no tearing), and a prescaled digit
// scan driven straight from the board clock.
// Optional feature macro: DISPLAY_SCHED_OWNER_DIGIT_EN -- when defined, digit 4
// shows the owner index as a hex glyph; otherwise digit 4 is always blank.
module display_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int DWELL_FRAMES = 512
) (
   input  logic               clock,
   input  logic               reset,
   display_scheduler_if.slave bus
);

   localparam int IW = (NUM_REQ > 2) ? 2 : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DWELL_FRAMES + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL_FRAMES);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   // Registered state and next-state values.
   logic [0:0]         state_q,   state_d;
   logic [NUM_REQ-1:0] grant_q,   grant_d;
   logic [IW-1:0]      owner_q,   owner_d;
   logic [IW-1:0]      rr_q,      rr_d;
   logic [PW-1:0]      presc_q,   presc_d;
   logic [2:0]         digit_q,   digit_d;
   logic [DW-1:0]      dwell_q,   dwell_d;
   logic [15:0]        shown_q,   shown_d;
   logic [7:0]         anode_q,   anode_d;
   logic [6:0]         cathode_q, cathode_d;

   // Combinational helpers.
   logic [NUM_REQ-1:0] req_v;
   logic [15:0]        src [NUM_REQ];
   logic               tick;
   logic               frame_end;
   logic               win_found;
   logic [IW-1:0]      win_idx;
   logic [IW-1:0]      cand;
   logic               owner_req;
   logic               others_pending;
   logic               dwell_done;
   logic               new_grant;
   logic               slot_on;
   logic [3:0]         slot_nib;
   logic [7:0]         slot_anode;
   logic [6:0]         slot_cathode;

   assign req_v = bus.req;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign src[gi] = bus.data[16*gi +: 16];
   end

   // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_seg = 7'h40;
         4'h1:    hex_to_seg = 7'h79;
         4'h2:    hex_to_seg = 7'h24;
         4'h3:    hex_to_seg = 7'h30;
         4'h4:    hex_to_seg = 7'h19;
         4'h5:    hex_to_seg = 7'h12;
         4'h6:    hex_to_seg = 7'h02;
         4'h7:    hex_to_seg = 7'h78;
         4'h8:    hex_to_seg = 7'h00;
         4'h9:    hex_to_seg = 7'h10;
         4'hA:    hex_to_seg = 7'h08;
         4'hB:    hex_to_seg = 7'h03;
         4'hC:    hex_to_seg = 7'h46;
         4'hD:    hex_to_seg = 7'h21;
         4'hE:    hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   // Digit-slot prescaler and digit index; both free-run in every state.
   assign tick      = (presc_q == PRESC_LAST);
   assign frame_end = tick && (digit_q == 3'd7);
   assign presc_d   = tick ? '0 : presc_q + 1'b1;
   assign digit_d   = tick ? digit_q + 3'd1 : digit_q;

   assign owner_req      = req_v[owner_q];
   assign others_pending = |(req_v & ~grant_q);
   assign dwell_done     = (dwell_q == DWELL_MAX);

   // Round-robin search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IW'((int'(rr_q) + k) % NUM_REQ);
         if (!win_found && req_v[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Ownership FSM, dwell counting and the tear-free value latch.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      dwell_d   = dwell_q;
      shown_d   = shown_q;
      new_grant = 1'b0;

      if (state_q == ST_IDLE) begin
         new_grant = win_found;
      end else if (!owner_req) begin
         // A drop wins over a simultaneous dwell expiry.
         if (win_found) begin
            new_grant = 1'b1;
         end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            dwell_d = '0;
         end
      end else if (dwell_done && others_pending) begin
         // The owner sits last in rr order, so another requester wins.
         new_grant = 1'b1;
      end

      if (new_grant) begin
         state_d = ST_OWN;
         owner_d = win_idx;
         grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
         rr_d    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         dwell_d = '0;
         // A frame wrap on the grant cycle also lands here: new owner's data.
         shown_d = src[win_idx];
      end else if ((state_q == ST_OWN) && (state_d == ST_OWN) && frame_end) begin
         shown_d = src[owner_q];
         if (!dwell_done) begin
            dwell_d = dwell_q + 1'b1;
         end
      end
   end

   // Glyph and anode for the digit slot that starts at the next tick.
   always_comb begin
      slot_on  = 1'b0;
      slot_nib = 4'h0;
      if (state_d == ST_OWN) begin
         case (digit_d)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               slot_nib = shown_d[{digit_d[1:0], 2'b00} +: 4];
               slot_on  = 1'b1;
            end
            3'd4: begin
`ifdef DISPLAY_SCHED_OWNER_DIGIT_EN
               slot_nib = {{(4-IW){1'b0}}, owner_d};
               slot_on  = 1'b1;
`endif
            end
            default: begin
               slot_on = 1'b0;
            end
         endcase
      end
      slot_anode   = slot_on ? ~(8'h01 << digit_d) : 8'hFF;
      slot_cathode = slot_on ? hex_to_seg(slot_nib) : 7'h7F;
   end

   // Scan outputs move only on slot ticks; leaving OWN blanks at once.
   always_comb begin
      anode_d   = anode_q;
      cathode_d = cathode_q;
      if (tick) begin
         anode_d   = slot_anode;
         cathode_d = slot_cathode;
      end else if (state_d == ST_IDLE) begin
         anode_d   = 8'hFF;
         cathode_d = 7'h7F;
      end
   end

   // All registers; synchronous reset returns every field to its idle value.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so each register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         presc_q   <= '0;
         digit_q   <= '0;
         dwell_q   <= '0;
         shown_q   <= '0;
         anode_q   <= 8'hFF;
         cathode_q <= 7'h7F;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         presc_q   <= presc_d;
         digit_q   <= digit_d;
         dwell_q   <= dwell_d;
         shown_q   <= shown_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.anode   = anode_q;
   assign bus.cathode = cathode_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: table-driven and scoreboard checks of display_scheduler
// with SCAN_DIV=4, DWELL_FRAMES=2, NUM_REQ=4.
module tb_display_scheduler;

   localparam int NUM_REQ      = 4;
   localparam int SCAN_DIV     = 4;
   localparam int DWELL_FRAMES = 2;
   localparam int FRAME_CYC    = 8 * SCAN_DIV;
   localparam int BUDGET       = 3 * FRAME_CYC;

   typedef struct packed {
      logic [3:0]      req;
      logic [15:0]     val;
      logic [3:0]      exp_grant;
      logic [4:0][6:0] exp_cat;   // digits 4..0, digit 4 = owner glyph
   } vec_t;

   typedef struct packed {
      logic [7:0] anode;
      logic [6:0] cathode;
   } slot_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic allow_ef;

   vec_t       vecs [4];
   logic [6:0] seg_tab [16];
   slot_t      slot_exp [$];
   logic [3:0] grant_exp [$];

   display_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   display_scheduler #(
      .NUM_REQ      (NUM_REQ),
      .SCAN_DIV     (SCAN_DIV),
      .DWELL_FRAMES (DWELL_FRAMES)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic apply_reset(input int n);
      reset   = 1'b1;
      bus.req = '0;
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic set_data(input int idx, input logic [15:0] val);
      bus.data[16*idx +: 16] = val;
   endtask

   // Poll at negedges (current sample first) until the anode pattern shows.
   task automatic wait_anode(input string name, input logic [7:0] pat,
                             output logic ok, output logic [6:0] cat);
      int n;
      n   = 0;
      ok  = 1'b0;
      cat = 7'h7F;
      while (n < BUDGET) begin
         if (bus.anode == pat) begin
            ok  = 1'b1;
            cat = bus.cathode;
            break;
         end
         @(negedge clock);
         n++;
      end
      if (!ok) fail_timeout(name);
   endtask

   // Pop expected digit slots in order and compare as the scan reaches them.
   task automatic drain_slots(input string name);
      slot_t      e;
      logic       ok;
      logic [6:0] cat;
      while (slot_exp.size() > 0) begin
         e = slot_exp.pop_front();
         wait_anode(name, e.anode, ok, cat);
         if (ok) check($sformatf("%s_an%0h", name, e.anode), 32'(cat), 32'(e.cathode));
      end
   endtask

   // Wait for the next lit digit slot after the current one.
   task automatic next_lit_slot(input string name, output logic ok,
                                output logic [7:0] an, output logic [6:0] cat);
      logic [7:0] start;
      int         n;
      start = bus.anode;
      ok    = 1'b0;
      an    = 8'hFF;
      cat   = 7'h7F;
      n     = 0;
      while (n < BUDGET && !ok) begin
         @(negedge clock);
         n++;
         if (bus.anode != start) begin
            if (bus.anode != 8'hFF) begin
               ok  = 1'b1;
               an  = bus.anode;
               cat = bus.cathode;
            end else begin
               start = 8'hFF;
            end
         end
      end
      if (!ok) fail_timeout(name);
   endtask

   initial begin
      logic       ok;
      logic [6:0] cat;
      logic [7:0] an;
      logic [3:0] prev_g;
      logic [3:0] exp_g;
      int         bad;
      int         oi;
      int         last_cyc;
      int         d;
      int         n;
      logic       changed;

`ifdef DISPLAY_SCHED_OWNER_DIGIT_EN
      allow_ef = 1'b1;
`else
      allow_ef = 1'b0;
`endif

      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      vecs[0] = '{req: 4'b0100, val: 16'h3A5F, exp_grant: 4'b0100,
                  exp_cat: {7'h24, 7'h30, 7'h08, 7'h12, 7'h0E}};
      vecs[1] = '{req: 4'b0001, val: 16'h0189, exp_grant: 4'b0001,
                  exp_cat: {7'h40, 7'h40, 7'h79, 7'h00, 7'h10}};
      vecs[2] = '{req: 4'b0010, val: 16'hBCDE, exp_grant: 4'b0010,
                  exp_cat: {7'h79, 7'h03, 7'h46, 7'h21, 7'h06}};
      vecs[3] = '{req: 4'b1000, val: 16'h4567, exp_grant: 4'b1000,
                  exp_cat: {7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};

      // Reset held three cycles, then idle with no requests.
      reset    = 1'b1;
      bus.req  = '0;
      bus.data = '0;
      repeat (3) @(negedge clock);
      check("rst_grant",   32'(bus.grant),   32'h0);
      check("rst_anode",   32'(bus.anode),   32'hFF);
      check("rst_cathode", 32'(bus.cathode), 32'h7F);
      reset = 1'b0;
      bad = 0;
      repeat (FRAME_CYC + 4) begin
         @(negedge clock);
         if (bus.anode != 8'hFF) bad++;
      end
      check("idle_anode_dark", 32'(bad), 32'h0);

      // Table: single requester, grant latency, full digit decode, release.
      for (int i = 0; i < 4; i++) begin
         bus.data = {16'hC0DE, 16'hBEEF, 16'hFACE, 16'hDEAD};
         oi = 0;
         for (int b = 0; b < NUM_REQ; b++) if (vecs[i].req[b]) oi = b;
         set_data(oi, vecs[i].val);
         bus.req = vecs[i].req;
         @(negedge clock);
         check($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].exp_grant));
         for (int dd = 0; dd < 4; dd++)
            slot_exp.push_back('{anode: ~(8'h01 << dd), cathode: vecs[i].exp_cat[dd]});
         if (allow_ef) slot_exp.push_back('{anode: 8'hEF, cathode: vecs[i].exp_cat[4]});
         drain_slots($sformatf("vec%0d", i));
         bad = 0;
         repeat (FRAME_CYC) begin
            @(negedge clock);
            an = bus.anode;
            if (!(an == 8'hFE || an == 8'hFD || an == 8'hFB || an == 8'hF7 ||
                  an == 8'hFF || (allow_ef && an == 8'hEF))) bad++;
            if (an == 8'hFF && bus.cathode != 7'h7F) bad++;
         end
         check($sformatf("vec%0d_scan_legal", i), 32'(bad), 32'h0);
         bus.req = '0;
         @(negedge clock);
         check($sformatf("vec%0d_release_grant", i), 32'(bus.grant), 32'h0);
         check($sformatf("vec%0d_release_anode", i), 32'(bus.anode), 32'hFF);
      end

      // All four requesting: rotation order, 64-cycle dwell, one-hot grant.
      apply_reset(2);
      bus.req = 4'b1111;
      grant_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      prev_g   = 4'b0000;
      last_cyc = 0;
      bad      = 0;
      for (int k = 0; k < 6; k++) begin
         exp_g   = grant_exp.pop_front();
         changed = 1'b0;
         n       = 0;
         while (n < BUDGET) begin
            @(negedge clock);
            n++;
            if (prev_g != 4'b0000 && !$onehot(bus.grant)) bad++;
            if (bus.grant != prev_g) begin
               changed = 1'b1;
               break;
            end
         end
         if (!changed) begin
            fail_timeout($sformatf("rr_change%0d", k));
         end else begin
            check($sformatf("rr_grant%0d", k), 32'(bus.grant), 32'(exp_g));
            if (k == 0) check("rr_first_latency", 32'(n), 32'd1);
            if (k >= 2) check($sformatf("rr_dwell%0d", k), 32'(cyc - last_cyc), 32'(2 * FRAME_CYC));
            last_cyc = cyc;
            prev_g   = bus.grant;
         end
      end
      check("rr_onehot", 32'(bad), 32'h0);

      // Owner 1 drops mid-frame while 3 waits: direct handoff, new value next slot.
      apply_reset(2);
      bus.data = {16'h9876, 16'hFACE, 16'h1111, 16'hDEAD};
      bus.req  = 4'b1010;
      @(negedge clock);
      check("drop_first_grant", 32'(bus.grant), 32'b0010);
      repeat (10) @(negedge clock);
      bus.req = 4'b1000;
      @(negedge clock);
      check("drop_handoff", 32'(bus.grant), 32'b1000);
      next_lit_slot("drop_slot", ok, an, cat);
      if (ok) begin
         d = 0;
         for (int b = 0; b < 8; b++) if (!an[b]) d = b;
         if (d < 4) check("drop_new_value", 32'(cat), 32'(seg_tab[(16'h9876 >> (4*d)) & 16'hF]));
         else       check("drop_new_owner_glyph", 32'(cat), 32'(seg_tab[3]));
      end

      // Data changes mid-frame: current frame intact, next frame new value.
      apply_reset(2);
      bus.data = {16'hC0DE, 16'hBEEF, 16'hFACE, 16'h1234};
      bus.req  = 4'b0001;
      @(negedge clock);
      check("tear_grant", 32'(bus.grant), 32'b0001);
      wait_anode("tear_sync", 8'hFE, ok, cat);
      set_data(0, 16'h5678);
      slot_exp.push_back('{anode: 8'hFE, cathode: 7'h19});
      slot_exp.push_back('{anode: 8'hFD, cathode: 7'h30});
      slot_exp.push_back('{anode: 8'hFB, cathode: 7'h24});
      slot_exp.push_back('{anode: 8'hF7, cathode: 7'h79});
      if (allow_ef) slot_exp.push_back('{anode: 8'hEF, cathode: 7'h40});
      slot_exp.push_back('{anode: 8'hFE, cathode: 7'h00});
      slot_exp.push_back('{anode: 8'hFD, cathode: 7'h78});
      slot_exp.push_back('{anode: 8'hFB, cathode: 7'h02});
      slot_exp.push_back('{anode: 8'hF7, cathode: 7'h12});
      drain_slots("tear");
      repeat (3 * FRAME_CYC) @(negedge clock);
      check("dwell_saturate_keep", 32'(bus.grant), 32'b0001);

      // Reset while owning, in the digit-5 slot; then rr_ptr must be back at 0.
      wait_anode("rst_sync_d2", 8'hFB, ok, cat);
      wait_anode("rst_sync_d3", 8'hF7, ok, cat);
      repeat (8) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_grant",   32'(bus.grant),   32'h0);
      check("midrst_anode",   32'(bus.anode),   32'hFF);
      check("midrst_cathode", 32'(bus.cathode), 32'h7F);
      reset   = 1'b0;
      bus.req = 4'b1001;
      @(negedge clock);
      check("midrst_rr_ptr", 32'(bus.grant), 32'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
